// File: rtl/dds_tone.sv
// dds_tone: direct-digital-synthesis tone source.
// A fractional rate accumulator produces a sample tick at an exact average
// rate of C_sample_freq from C_clk_freq. On each tick the phase advances by
// freq_word and the clamped gain is captured. The sine comes from a
// quarter-wave ROM with quadrant mirroring and a gain multiply. The tick
// occurs in cycle T, and pcm_valid pulses in cycle T+3.
// Optional build macro DDS_TRIANGLE_EN adds the wave_sel input, which selects
// a triangle waveform through the same pipeline and gain path.
module dds_tone #(
    parameter int unsigned C_clk_freq    = 25000000,
    parameter int unsigned C_sample_freq = 48000,
    parameter int unsigned C_phase_bits  = 24,
    parameter int unsigned C_lut_bits    = 8,
    parameter int unsigned C_pcm_bits    = 12
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [C_phase_bits-1:0]      freq_word,
    input  logic [8:0]                   gain,
`ifdef DDS_TRIANGLE_EN
    input  logic                         wave_sel,
`endif
    output logic signed [C_pcm_bits-1:0] pcm,
    output logic                         pcm_valid
);

    localparam int unsigned C_acc_w     = 32;
    localparam int unsigned C_gain_w    = 9;
    localparam int unsigned C_mag_w     = C_pcm_bits - 1;
    localparam int unsigned C_rom_depth = 1 << C_lut_bits;
    localparam int unsigned C_prod_w    = C_pcm_bits + C_gain_w + 1;
    localparam int unsigned C_msb       = C_phase_bits - 1;
    localparam logic [C_gain_w-1:0] C_unity = C_gain_w'(256);

    // Q30 fixed-point constants used only while building the ROM.
    localparam longint C_pi_q30   = 64'sd3373259426;
    localparam longint C_half_q30 = 64'sd536870912;
    localparam longint C_amp      = longint'((1 << C_mag_w) - 1);

    // Evaluates one ROM entry: round(C_amp * sin(pi/2 * (k+0.5) / depth)).
    function automatic logic [C_mag_w-1:0] sine_entry(input int unsigned k);
        longint x;
        longint x2;
        longint term;
        longint sum;
        x    = (C_pi_q30 * longint'(2 * k + 1)) / longint'(4 * C_rom_depth);
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int n = 1; n < 8; n++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
            sum  = sum + term;
        end
        return C_mag_w'((sum * C_amp + C_half_q30) >>> 30);
    endfunction

    // Quarter-wave table, fixed at elaboration.
    logic [C_mag_w-1:0] rom_c [C_rom_depth];
    for (genvar g = 0; g < C_rom_depth; g++) begin : g_rom
        localparam logic [C_mag_w-1:0] C_entry = sine_entry(g);
        assign rom_c[g] = C_entry;
    end

    logic [C_acc_w-1:0]          acc_q, acc_d;
    logic [C_acc_w:0]            acc_sum_c;
    logic                        tick_c;
    logic [C_phase_bits-1:0]     phase_q, phase_d;
    logic [C_gain_w-1:0]         gain0_q, gain0_d;
    logic                        v0_q, v0_d;
    logic [C_lut_bits-1:0]       idx_c, addr_c;
    logic [C_mag_w-1:0]          mag_c;
    logic [C_mag_w-1:0]          mag1_q, mag1_d;
    logic                        neg1_q, neg1_d;
    logic [C_gain_w-1:0]         gain1_q, gain1_d;
    logic                        v1_q, v1_d;
    logic signed [C_pcm_bits-1:0] s_c;
    logic signed [C_prod_w-1:0]  prod_c;
    logic signed [C_pcm_bits-1:0] pcm_q, pcm_d;
    logic                        pcm_valid_q, pcm_valid_d;
`ifdef DDS_TRIANGLE_EN
    logic                        wave0_q, wave0_d;
    logic [C_mag_w-1:0]          tri_c;
`endif

    // Rate tick, stage 0 (phase/gain capture) and stage 1 (ROM addressing).
    always_comb begin
        acc_sum_c = {1'b0, acc_q} + (C_acc_w + 1)'(C_sample_freq);
        tick_c    = (acc_sum_c >= (C_acc_w + 1)'(C_clk_freq));
        acc_d     = tick_c ? C_acc_w'(acc_sum_c - (C_acc_w + 1)'(C_clk_freq))
                           : C_acc_w'(acc_sum_c);

        phase_d = phase_q;
        gain0_d = gain0_q;
        v0_d    = tick_c;
`ifdef DDS_TRIANGLE_EN
        wave0_d = wave0_q;
`endif
        if (tick_c) begin
            phase_d = phase_q + freq_word;
            gain0_d = (gain > C_unity) ? C_unity : gain;
`ifdef DDS_TRIANGLE_EN
            wave0_d = wave_sel;
`endif
        end

        idx_c  = phase_q[C_msb-2 -: C_lut_bits];
        addr_c = phase_q[C_msb-1] ? ~idx_c : idx_c;
        mag_c  = rom_c[addr_c];
`ifdef DDS_TRIANGLE_EN
        tri_c  = phase_q[C_msb-1] ? ~phase_q[C_msb-2 -: C_mag_w]
                                  : phase_q[C_msb-2 -: C_mag_w];
        if (wave0_q) begin
            mag_c = tri_c;
        end
`endif
        mag1_d  = v0_q ? mag_c : mag1_q;
        neg1_d  = v0_q ? phase_q[C_msb] : neg1_q;
        gain1_d = v0_q ? gain0_q : gain1_q;
        v1_d    = v0_q;
    end

    // Stage 2: sign restore, gain multiply and floor-shift to the output width.
    always_comb begin
        s_c         = neg1_q ? -$signed({1'b0, mag1_q}) : $signed({1'b0, mag1_q});
        prod_c      = C_prod_w'(s_c) * C_prod_w'($signed({1'b0, gain1_q}));
        pcm_d       = v1_q ? C_pcm_bits'(prod_c >>> 8) : pcm_q;
        pcm_valid_d = v1_q;
    end

    // Pipeline and accumulator registers; reset discards in-flight samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            phase_q     <= '0;
            gain0_q     <= '0;
            v0_q        <= 1'b0;
            mag1_q      <= '0;
            neg1_q      <= 1'b0;
            gain1_q     <= '0;
            v1_q        <= 1'b0;
            pcm_q       <= '0;
            pcm_valid_q <= 1'b0;
`ifdef DDS_TRIANGLE_EN
            wave0_q     <= 1'b0;
`endif
        end else begin
            acc_q       <= acc_d;
            phase_q     <= phase_d;
            gain0_q     <= gain0_d;
            v0_q        <= v0_d;
            mag1_q      <= mag1_d;
            neg1_q      <= neg1_d;
            gain1_q     <= gain1_d;
            v1_q        <= v1_d;
            pcm_q       <= pcm_d;
            pcm_valid_q <= pcm_valid_d;
`ifdef DDS_TRIANGLE_EN
            wave0_q     <= wave0_d;
`endif
        end
    end

    assign pcm       = pcm_q;
    assign pcm_valid = pcm_valid_q;

endmodule
